// File: rtl/csr_req_gen.sv
// rtl/csr_req_gen.sv - writeback-side CSR request generator with trap/ERTN flush sequencing
module csr_req_gen #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [1:0]  in_csr_op,
  input  logic [13:0] in_csr_num,
  input  logic [31:0] in_rd_val,
  input  logic [31:0] in_rj_val,
  input  logic [4:0]  in_rd,
  input  logic        in_ertn,
  input  logic [4:0]  in_ex,
  input  logic [31:0] in_badv,
  output logic [79:0] csr_ctrl,
  input  logic [31:0] csr_rvalue,
  output logic [48:0] CSR_in_bus,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era_pc,
  input  logic        has_int,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic [31:0] retire_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state, state_nxt;
  logic [3:0]  fcnt, fcnt_nxt;
  logic        flush_nxt;
  logic [31:0] flush_pc_nxt;

  logic        st_valid;
  logic [31:0] st_pc;
  logic [1:0]  st_op;
  logic [13:0] st_num;
  logic [31:0] st_rd_val;
  logic [31:0] st_rj_val;
  logic [4:0]  st_rd;
  logic        st_ertn;
  logic [4:0]  st_ex;

  logic        wb_ex;
  logic        ertn_flush;
  logic [5:0]  ecode;
  logic        csr_act;
  logic        csr_re;
  logic        csr_we;
  logic [31:0] csr_wmask;

  // The fault address is carried on the port for a later revision only.
  logic unused_badv;
  assign unused_badv = ^in_badv;

  assign in_ready = (state == RUN);

  // Stage register: capture one retiring instruction per handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_valid  <= 1'b0;
      st_pc     <= '0;
      st_op     <= '0;
      st_num    <= '0;
      st_rd_val <= '0;
      st_rj_val <= '0;
      st_rd     <= '0;
      st_ertn   <= 1'b0;
      st_ex     <= '0;
    end else begin
      st_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        st_pc     <= in_pc;
        st_op     <= in_csr_op;
        st_num    <= in_csr_num;
        st_rd_val <= in_rd_val;
        st_rj_val <= in_rj_val;
        st_rd     <= in_rd;
        st_ertn   <= in_ertn;
        st_ex     <= in_ex;
      end
    end
  end

  // Exception priority: interrupt, adef, ine, sys, brk, ale.
  always_comb begin
    ecode = 6'h00;
    if (st_valid && !has_int) begin
      if (st_ex[4])      ecode = 6'h08;
      else if (st_ex[3]) ecode = 6'h0D;
      else if (st_ex[2]) ecode = 6'h0B;
      else if (st_ex[1]) ecode = 6'h0C;
      else if (st_ex[0]) ecode = 6'h09;
    end
  end

  assign wb_ex      = st_valid && (has_int || (|st_ex));
  assign ertn_flush = st_valid && st_ertn && !wb_ex;
  assign CSR_in_bus = {ertn_flush, wb_ex, ecode, 9'h000, st_valid ? st_pc : 32'h0};

  // CSR access is suppressed entirely by any exception, including an interrupt.
  assign csr_act = st_valid && (st_op != 2'b00) && !wb_ex;
  assign csr_re  = csr_act;
  assign csr_we  = csr_act && st_op[1];

  // Write mask by op: csrwr writes all bits, csrxchg uses rj as the mask.
  always_comb begin
    csr_wmask = 32'h0;
    if (csr_act) begin
      case (st_op)
        2'b10:   csr_wmask = 32'hFFFF_FFFF;
        2'b11:   csr_wmask = st_rj_val;
        default: csr_wmask = 32'h0;
      endcase
    end
  end

  assign csr_ctrl = csr_act ? {st_num, csr_re, csr_we, st_rd_val, csr_wmask} : 80'h0;

  // rd receives the pre-write CSR value; the CSR write lands at the clock edge.
  assign rf_we    = csr_re;
  assign rf_waddr = csr_re ? st_rd : 5'h0;
  assign rf_wdata = csr_re ? csr_rvalue : 32'h0;

  // Count every commit that does not trap (ERTN included), wrapping naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt <= '0;
    end else if (st_valid && !wb_ex) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  // Flush FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RUN;
      fcnt     <= '0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else begin
      state    <= state_nxt;
      fcnt     <= fcnt_nxt;
      flush    <= flush_nxt;
      flush_pc <= flush_pc_nxt;
    end
  end

  // Flush FSM next state: a trap/ERTN commit starts a FLUSH_CYCLES-long flush.
  always_comb begin
    state_nxt    = state;
    fcnt_nxt     = fcnt;
    flush_nxt    = flush;
    flush_pc_nxt = flush_pc;
    case (state)
      RUN: begin
        if (wb_ex || ertn_flush) begin
          state_nxt    = FLUSH;
          fcnt_nxt     = 4'(FLUSH_CYCLES - 1);
          flush_nxt    = 1'b1;
          flush_pc_nxt = wb_ex ? ex_entry : era_pc;
        end
      end
      FLUSH: begin
        if (fcnt == 4'd0) begin
          state_nxt = RUN;
          flush_nxt = 1'b0;
        end else begin
          fcnt_nxt = fcnt - 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        flush_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_req_gen.sv
// tb/tb_csr_req_gen.sv - directed self-checking bench for csr_req_gen
module tb_csr_req_gen;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [1:0]  in_csr_op;
  logic [13:0] in_csr_num;
  logic [31:0] in_rd_val;
  logic [31:0] in_rj_val;
  logic [4:0]  in_rd;
  logic        in_ertn;
  logic [4:0]  in_ex;
  logic [31:0] in_badv;
  logic [31:0] csr_rvalue;
  logic [31:0] ex_entry;
  logic [31:0] era_pc;
  logic        has_int;

  logic        in_ready;
  logic [79:0] csr_ctrl;
  logic [48:0] CSR_in_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic [31:0] retire_cnt;

  logic        in_ready_b;
  logic [79:0] csr_ctrl_b;
  logic [48:0] CSR_in_bus_b;
  logic        rf_we_b;
  logic [4:0]  rf_waddr_b;
  logic [31:0] rf_wdata_b;
  logic        flush_b;
  logic [31:0] flush_pc_b;
  logic [31:0] retire_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  csr_req_gen #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_csr_op(in_csr_op), .in_csr_num(in_csr_num),
    .in_rd_val(in_rd_val), .in_rj_val(in_rj_val), .in_rd(in_rd),
    .in_ertn(in_ertn), .in_ex(in_ex), .in_badv(in_badv),
    .csr_ctrl(csr_ctrl), .csr_rvalue(csr_rvalue), .CSR_in_bus(CSR_in_bus),
    .ex_entry(ex_entry), .era_pc(era_pc), .has_int(has_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flush(flush), .flush_pc(flush_pc), .retire_cnt(retire_cnt)
  );

  csr_req_gen #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pc(in_pc), .in_csr_op(in_csr_op), .in_csr_num(in_csr_num),
    .in_rd_val(in_rd_val), .in_rj_val(in_rj_val), .in_rd(in_rd),
    .in_ertn(in_ertn), .in_ex(in_ex), .in_badv(in_badv),
    .csr_ctrl(csr_ctrl_b), .csr_rvalue(csr_rvalue), .CSR_in_bus(CSR_in_bus_b),
    .ex_entry(ex_entry), .era_pc(era_pc), .has_int(has_int),
    .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b),
    .flush(flush_b), .flush_pc(flush_pc_b), .retire_cnt(retire_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [13:0] num, input logic [31:0] pc,
                           input logic [31:0] rd_val, input logic [31:0] rj_val,
                           input logic [4:0] rd, input logic ertn, input logic [4:0] ex);
    in_csr_op  = op;
    in_csr_num = num;
    in_pc      = pc;
    in_rd_val  = rd_val;
    in_rj_val  = rj_val;
    in_rd      = rd;
    in_ertn    = ertn;
    in_ex      = ex;
  endtask

  // Present one instruction for a single handshake; returns in its commit cycle.
  task automatic issue(input logic [1:0] op, input logic [13:0] num, input logic [31:0] pc,
                       input logic [31:0] rd_val, input logic [31:0] rj_val,
                       input logic [4:0] rd, input logic ertn, input logic [4:0] ex);
    set_instr(op, num, pc, rd_val, rj_val, rd, ertn, ex);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 1'b0;
    set_instr(2'b00, 14'h0, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 5'h0);
    in_badv = 32'h0; csr_rvalue = 32'h0; ex_entry = 32'h0; era_pc = 32'h0; has_int = 1'b0;
    repeat (3) cyc();
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %h expected 1", in_ready); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %h expected 0", flush); end
    n_checks++; if (flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc: got %h expected 0", flush_pc); end
    n_checks++; if (retire_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_retire_cnt: got %h expected 0", retire_cnt); end
    n_checks++; if (csr_ctrl !== 80'h0) begin n_fail++; $display("FAIL reset_csr_ctrl: got %h expected 0", csr_ctrl); end
    n_checks++; if (CSR_in_bus !== 49'h0) begin n_fail++; $display("FAIL reset_csr_in_bus: got %h expected 0", CSR_in_bus); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %h expected 0", rf_we); end
  endtask

  task automatic test_csrwr();
    csr_rvalue = 32'h0000_0011;
    issue(2'b10, 14'h030, 32'h1C00_0000, 32'hDEAD_BEEF, 32'hAAAA_5555, 5'd5, 1'b0, 5'h0);
    @(negedge clk);
    n_checks++; if (csr_ctrl !== {14'h030, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF})
      begin n_fail++; $display("FAIL csrwr_ctrl: got %h expected %h", csr_ctrl, {14'h030, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FFFF}); end
    n_checks++; if (CSR_in_bus !== {1'b0, 1'b0, 6'h00, 9'h000, 32'h1C00_0000})
      begin n_fail++; $display("FAIL csrwr_in_bus: got %h", CSR_in_bus); end
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h0000_0011})
      begin n_fail++; $display("FAIL csrwr_rf: got %h %h %h expected 1 05 00000011", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (retire_cnt !== 32'd0) begin n_fail++; $display("FAIL csrwr_cnt_before: got %h expected 0", retire_cnt); end
    cyc();
    n_checks++; if (retire_cnt !== 32'd1) begin n_fail++; $display("FAIL csrwr_cnt_after: got %h expected 1", retire_cnt); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL csrwr_no_flush: got %h expected 0", flush); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL csrwr_one_cycle: got %h expected 0", rf_we); end
  endtask

  task automatic test_xchg_rd();
    csr_rvalue = 32'hCAFE_0001;
    issue(2'b11, 14'h006, 32'h1C00_0010, 32'h1234_5678, 32'h0000_FF00, 5'd7, 1'b0, 5'h0);
    @(negedge clk);
    n_checks++; if (csr_ctrl !== {14'h006, 1'b1, 1'b1, 32'h1234_5678, 32'h0000_FF00})
      begin n_fail++; $display("FAIL xchg_ctrl: got %h", csr_ctrl); end
    n_checks++; if (rf_wdata !== 32'hCAFE_0001) begin n_fail++; $display("FAIL xchg_rf_wdata: got %h expected cafe0001", rf_wdata); end
    issue(2'b01, 14'h005, 32'h1C00_0014, 32'h0BAD_F00D, 32'hFFFF_FFFF, 5'd9, 1'b0, 5'h0);
    @(negedge clk);
    n_checks++; if (csr_ctrl !== {14'h005, 1'b1, 1'b0, 32'h0BAD_F00D, 32'h0})
      begin n_fail++; $display("FAIL rd_ctrl: got %h", csr_ctrl); end
    n_checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL rd_rf: got %h %h expected 1 09", rf_we, rf_waddr); end
    cyc();
    n_checks++; if (retire_cnt !== 32'd3) begin n_fail++; $display("FAIL xchg_rd_cnt: got %h expected 3", retire_cnt); end
  endtask

  task automatic test_syscall();
    ex_entry = 32'h1C00_8000;
    era_pc   = 32'h1C00_0104;
    issue(2'b10, 14'h030, 32'h1C00_0100, 32'h1, 32'h2, 5'd3, 1'b0, 5'b00100);
    @(negedge clk);
    n_checks++; if (CSR_in_bus !== {1'b0, 1'b1, 6'h0B, 9'h000, 32'h1C00_0100})
      begin n_fail++; $display("FAIL sys_in_bus: got %h", CSR_in_bus); end
    n_checks++; if (csr_ctrl !== 80'h0) begin n_fail++; $display("FAIL sys_ctrl: got %h expected 0", csr_ctrl); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL sys_rf_we: got %h expected 0", rf_we); end
    cyc();
    set_instr(2'b01, 14'h001, 32'h1C00_8000, 32'h0, 32'h0, 5'd4, 1'b0, 5'h0);
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if ({flush, in_ready, flush_pc} !== {1'b1, 1'b0, 32'h1C00_8000})
      begin n_fail++; $display("FAIL sys_flush1: got %h %h %h expected 1 0 1c008000", flush, in_ready, flush_pc); end
    n_checks++; if (flush_b !== 1'b1) begin n_fail++; $display("FAIL sys_flush1_n1: got %h expected 1", flush_b); end
    n_checks++; if (retire_cnt !== 32'd3) begin n_fail++; $display("FAIL sys_cnt: got %h expected 3", retire_cnt); end
    cyc();
    @(negedge clk);
    n_checks++; if ({flush, in_ready} !== 2'b10) begin n_fail++; $display("FAIL sys_flush2: got %h %h expected 1 0", flush, in_ready); end
    n_checks++; if (flush_b !== 1'b0) begin n_fail++; $display("FAIL sys_flush2_n1: got %h expected 0", flush_b); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL sys_no_capture: got %h expected 0", rf_we); end
    cyc();
    @(negedge clk);
    n_checks++; if ({flush, in_ready, flush_pc} !== {1'b0, 1'b1, 32'h1C00_8000})
      begin n_fail++; $display("FAIL sys_flush_end: got %h %h %h expected 0 1 1c008000", flush, in_ready, flush_pc); end
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({rf_we, rf_waddr} !== {1'b1, 5'd4}) begin n_fail++; $display("FAIL sys_resume: got %h %h expected 1 04", rf_we, rf_waddr); end
    cyc();
    n_checks++; if (retire_cnt !== 32'd4) begin n_fail++; $display("FAIL sys_resume_cnt: got %h expected 4", retire_cnt); end
  endtask

  task automatic test_ertn();
    era_pc = 32'h1C00_0104;
    issue(2'b00, 14'h0, 32'h1C00_0200, 32'h0, 32'h0, 5'd0, 1'b1, 5'h0);
    @(negedge clk);
    n_checks++; if (CSR_in_bus !== {1'b1, 1'b0, 6'h00, 9'h000, 32'h1C00_0200})
      begin n_fail++; $display("FAIL ertn_in_bus: got %h", CSR_in_bus); end
    cyc();
    n_checks++; if ({flush, flush_pc} !== {1'b1, 32'h1C00_0104})
      begin n_fail++; $display("FAIL ertn_flush: got %h %h expected 1 1c000104", flush, flush_pc); end
    n_checks++; if (retire_cnt !== 32'd5) begin n_fail++; $display("FAIL ertn_cnt: got %h expected 5", retire_cnt); end
    repeat (2) cyc();
    n_checks++; if ({flush, in_ready} !== 2'b01) begin n_fail++; $display("FAIL ertn_done: got %h %h expected 0 1", flush, in_ready); end
  endtask

  task automatic test_int_priority();
    ex_entry = 32'h1C00_9000;
    has_int  = 1'b1;
    cyc();
    @(negedge clk);
    n_checks++; if (CSR_in_bus !== 49'h0) begin n_fail++; $display("FAIL int_idle_bus: got %h expected 0", CSR_in_bus); end
    cyc();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL int_idle_flush: got %h expected 0", flush); end
    issue(2'b10, 14'h030, 32'h1C00_0300, 32'h5, 32'h6, 5'd8, 1'b1, 5'b01000);
    @(negedge clk);
    n_checks++; if (CSR_in_bus !== {1'b0, 1'b1, 6'h00, 9'h000, 32'h1C00_0300})
      begin n_fail++; $display("FAIL int_in_bus: got %h", CSR_in_bus); end
    n_checks++; if ({csr_ctrl, rf_we} !== 81'h0) begin n_fail++; $display("FAIL int_no_access: got %h %h expected 0", csr_ctrl, rf_we); end
    cyc();
    has_int = 1'b0;
    n_checks++; if ({retire_cnt, flush, flush_pc} !== {32'd5, 1'b1, 32'h1C00_9000})
      begin n_fail++; $display("FAIL int_after: got %h %h %h expected 5 1 1c009000", retire_cnt, flush, flush_pc); end
    repeat (2) cyc();
  endtask

  task automatic test_reset_mid_flush();
    ex_entry = 32'h1C00_A000;
    issue(2'b00, 14'h0, 32'h1C00_0400, 32'h0, 32'h0, 5'd0, 1'b0, 5'b10001);
    @(negedge clk);
    n_checks++; if (CSR_in_bus !== {1'b0, 1'b1, 6'h08, 9'h000, 32'h1C00_0400})
      begin n_fail++; $display("FAIL adef_prio: got %h", CSR_in_bus); end
    cyc();
    cyc();
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL mid_flush_second: got %h expected 1", flush); end
    resetn = 1'b0;
    #1;
    n_checks++; if ({flush, in_ready, retire_cnt, flush_pc} !== {1'b0, 1'b1, 32'd0, 32'd0})
      begin n_fail++; $display("FAIL mid_flush_reset: got %h %h %h %h expected 0 1 0 0", flush, in_ready, retire_cnt, flush_pc); end
    cyc();
    resetn = 1'b1;
    cyc();
    n_checks++; if ({flush, in_ready} !== 2'b01) begin n_fail++; $display("FAIL post_reset: got %h %h expected 0 1", flush, in_ready); end
  endtask

  initial begin
    test_reset();
    test_csrwr();
    test_xchg_rd();
    test_syscall();
    test_ertn();
    test_int_priority();
    test_reset_mid_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_req_gen.md
Name: csr_req_gen

Overview:
- Writeback-side producer of the CSR unit's two request buses.
- Accepts one retiring instruction per handshake and resolves exception priority, including the sampled interrupt.
- Drives the instruction bus `csr_ctrl` and the trap bus `CSR_in_bus`, then writes the old CSR value back to the register file.
- After an exception or ERTN it owns the pipeline flush sequence and supplies the redirect PC.

Parameters:
- FLUSH_CYCLES, 2, cycles `flush` stays high after a trapping or ERTN commit (legal range 1..15).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a retiring instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_pc  in  32  instruction PC.
- in_csr_op  in  2  00 none, 01 csrrd, 10 csrwr, 11 csrxchg.
- in_csr_num  in  14  CSR number.
- in_rd_val  in  32  rd source value, used as write data.
- in_rj_val  in  32  rj value, used as the xchg mask.
- in_rd  in  5  destination register index.
- in_ertn  in  1  ERTN instruction.
- in_ex  in  5  {adef, ine, sys, brk, ale} flags.
- in_badv  in  32  fault address (reserved, unused this revision).
- csr_ctrl  out  80  {num[13:0], re, we, wvalue[31:0], wmask[31:0]}.
- csr_rvalue  in  32  CSR read data (combinational).
- CSR_in_bus  out  49  {ertn_flush, wb_ex, ecode[5:0], esubcode[8:0], pc[31:0]}.
- ex_entry  in  32  exception entry address.
- era_pc  in  32  return address.
- has_int  in  1  pending enabled interrupt.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write index.
- rf_wdata  out  32  register-file write data.
- flush  out  1  pipeline flush.
- flush_pc  out  32  redirect target.
- retire_cnt  out  32  count of non-trapping commits.

Behaviour:
- Reset (async, resetn=0) clears everything:
  - state=RUN, st_valid=0, flush=0, flush_pc=0, retire_cnt=0.
  - All other outputs 0 via st_valid gating.
  - in_ready=1 once reset is released.
- Capture:
  - in_ready = (state==RUN).
  - On in_valid&&in_ready, all in_* fields are registered into the stage and st_valid=1 on the next cycle.
  - If the capture does not recur, st_valid clears after one cycle.
- Commit cycle (st_valid=1): every output is combinational from the stage registers plus `has_int`/`csr_rvalue` sampled in this cycle. Commit latency is exactly 1 cycle after the handshake.
- Exception resolution, highest priority first:

  | Source | ecode | esubcode |
  |---|---|---|
  | has_int | 0x00 | 0 |
  | adef | 0x08 | 0 |
  | ine | 0x0D | 0 |
  | sys | 0x0B | 0 |
  | brk | 0x0C | 0 |
  | ale | 0x09 | 0 |

  - wb_ex = st_valid && any of the above.
  - When wb_ex=0, ecode/esubcode are 0.
- CSR_in_bus:
  - pc = stage pc when st_valid, else 0.
  - ertn_flush = st_valid && ertn && !wb_ex.
- csr_ctrl:
  - Active only if st_valid && op!=00 && !wb_ex.
  - re = 1 for all CSR ops.
  - we = 1 for op 10 and op 11.
  - wvalue = rd_val.
  - wmask = 32'hFFFFFFFF for csrwr, rj_val for csrxchg, 0 for csrrd.
  - Whole bus = 0 otherwise.
- Register-file write: rf_we = csr_ctrl.re, rf_waddr = rd, rf_wdata = csr_rvalue (the old value, since the write takes effect at the clock edge). When rf_we=0, rf_waddr and rf_wdata are 0.
- Retire counter:
  - retire_cnt increments on each commit with wb_ex=0 (ERTN included).
  - Wraps 0xFFFFFFFF→0.
- FSM (RUN, FLUSH):
  - RUN→FLUSH on a commit with wb_ex||ertn_flush. At that edge: flush_pc <= wb_ex ? ex_entry : era_pc; fcnt <= FLUSH_CYCLES-1; flush <= 1.
  - In FLUSH: in_ready=0, so no capture. Each cycle fcnt decrements. When fcnt==0, next state is RUN and flush <= 0.
  - flush is high for exactly FLUSH_CYCLES cycles.
  - flush_pc holds its value until the next trap.
- Simultaneous events:
  - Interrupt plus ERTN on the same commit: the interrupt wins; ertn_flush=0, no CSR access.
  - An interrupt asserted while st_valid=0 is ignored; it is taken on the next committing instruction.
- Reset mid-FLUSH aborts the sequence immediately: flush=0, state=RUN.

Test Plan:
- csrwr num=0x30, rd_val=0xDEADBEEF, csr_rvalue=0x11 → commit cycle: csr_ctrl={0x30,1,1,0xDEADBEEF,0xFFFFFFFF}, rf_we=1, rf_wdata=0x11, retire_cnt 0→1.
- csrxchg rj_val=0x0000FF00, rd_val=0x12345678 → wmask=0x0000FF00, wvalue=0x12345678; csrrd → we=0, wmask=0.
- syscall at pc=0x1C000100, ex_entry=0x1C008000 → CSR_in_bus={0,1,0x0B,0,0x1C000100}, csr_ctrl=0, rf_we=0; flush high for 2 cycles with flush_pc=0x1C008000; in_valid held → in_ready low for 2 cycles.
- ertn with era_pc=0x1C000104 → ertn_flush=1, wb_ex=0, flush_pc=0x1C000104, retire_cnt increments.
- has_int=1 together with csrwr carrying ine → ecode=0x00 (interrupt wins), no CSR write, no rf write, retire_cnt unchanged.
- resetn pulsed low in the second FLUSH cycle → flush=0, in_ready=1, retire_cnt=0 immediately; with FLUSH_CYCLES=1, flush is high for exactly 1 cycle.
